systolic_result_drain: RTL and testbench
========================================

# systolic_result_drain

Consumer side of the systolic array's result interface. It captures each 128-bit `final_result` frame qualified by `valid_out`, buffers up to `DEPTH` frames, and streams each frame out as four 32-bit words on a valid/ready handshake. Frames that arrive while the buffer is full are dropped and counted. It sits between the 4x4 array top and any narrow downstream sink (bus bridge, UART packer, scoreboard).

## Interface
- `DATA_W`, 128: frame width (16 x 8-bit result lanes).
- `WORD_W`, 32: output word width; `DATA_W` must be an integer multiple of it.
- `DEPTH`, 2: frame buffer depth; power of two, 2 or more.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `res_valid_in` in 1: frame strobe, driven from the array's `valid_out`.
- `res_in` in DATA_W: frame data (`final_result`); sampled only when `res_valid_in` is 1.
- `word_out` out WORD_W: current output word.
- `word_valid` out 1: `word_out` is valid.
- `word_ready` in 1: sink accepts the word.
- `word_last` out 1: the current word is the final word of its frame.
- `word_idx` out 2: index of the current word within its frame.
- `overflow` out 1: sticky flag, set when any frame has been dropped.
- `drop_cnt` out 8: number of dropped frames, saturating.
- `clr_stat` in 1: synchronous clear of `overflow` and `drop_cnt`.
- `busy` out 1: buffer is non-empty.

## Operation
- `WORDS = DATA_W/WORD_W` (4). Word k is `res_in[k*WORD_W +: WORD_W]`. Words go out in order k = 0, 1, 2, 3, so word 0 carries bits [31:0].
- **Push:** `res_valid_in` = 1 and the buffer is not full. The frame is written at the write pointer and occupancy increments.
- **Drop:** `res_valid_in` = 1 and the buffer is full, with no same-cycle pop. The frame is discarded, `overflow` is set to 1 and `drop_cnt` increments, holding at 255.
- **Word transfer:** occurs when `word_valid` and `word_ready` are both 1. `word_idx` increments. On a transfer with `word_idx` = WORDS-1, the head frame pops and `word_idx` returns to 0.
- **Push and pop in the same cycle:** pop takes priority. A full buffer that pops its last word in the same cycle as a `res_valid_in` strobe accepts the frame; this is not a drop.
- `word_valid` = `busy` = (occupancy ≠ 0).
- `word_out` always comes from the head frame at `word_idx`.
- `word_last` = `word_valid` and (`word_idx` = WORDS-1).
- While `word_valid` = 1 and `word_ready` = 0, `word_out`, `word_idx` and `word_last` hold stable.
- Two-state control:
  - EMPTY → SEND on push.
  - SEND → EMPTY when the last word transfers and no frame is pushed in that cycle with occupancy = 1.
- `clr_stat`:
  - Zeroes `overflow` and `drop_cnt` on the next edge.
  - If it coincides with a drop, the clear wins: the result is 0/0.
  - It does not affect buffered data.
- Occupancy counter is log2(DEPTH)+1 bits. Read and write pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- Reset values:
  - `word_valid`, `word_last`, `busy`, `overflow` = 0.
  - `word_idx` = 0, `drop_cnt` = 0, `word_out` = 0.
  - Pointers and occupancy = 0; the state is EMPTY.
- Latency: if the strobe is sampled at edge N into an empty buffer, `word_valid` = 1 and word 0 appear after edge N. With `word_ready` held at 1, the frame drains in 4 cycles.
- Throughput is one word per cycle. Sustained input is therefore 1 frame per 4 cycles without loss.
- Asserting `reset` mid-frame clears all state immediately, independent of the clock. Partially sent frames are lost, and after release the block waits for a new strobe.
- `res_in` is registered into the buffer on the edge where the strobe is sampled. There is no combinational path from `res_in` to `word_out` in the same cycle.

## Structure
- Shared package `systolic_pkg`: `DATA_W`, `WORD_W`, `WORDS`, the lane width (8), and the `drain_state_t` enum {EMPTY, SEND}.
- One sub-module, `frame_fifo`, owns the DEPTH x DATA_W storage, pointers, occupancy and full/empty, with pop-before-push semantics. The top owns the word index, the state, word selection and the statistics.

## Test plan
- **Single frame:** strobe a frame whose words are 0x00000001, 0x00000002, 0x00000003, 0x00000004, with `word_ready` = 1. Required: words 1, 2, 3, 4 in order on consecutive cycles, `word_last` only on 4, then `busy` = 0.
- **Overflow:** hold `word_ready` = 0 and strobe frames A, B, C. Required: A and B are buffered, C is dropped, `overflow` = 1, `drop_cnt` = 1. After raising `word_ready`, the output is A0..A3 then B0..B3.
- **Simultaneous pop and push:** with the buffer full, strobe frame D in the same cycle as the last word of the head frame transfers. Required: D is accepted, `drop_cnt` is unchanged, and D drains after the remaining frame.
- **Backpressure:** toggle `word_ready` 1,0,0,1,0,1,1 during a frame. Required: no word is skipped or duplicated, and the outputs stay stable while ready is 0.
- **Saturation and clear:** cause 300 drops. Required: `drop_cnt` = 255. Then pulse `clr_stat` on the same cycle as one further drop. Required: `drop_cnt` = 0 and `overflow` = 0.
- **Reset mid-frame:** assert `reset` after word 1 of a frame has transferred. Required: all outputs read their reset values at once. A new frame after release starts at `word_idx` = 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg
// Shared constants and types for the systolic array result path.
//   DATA_W  - width of one result frame (16 lanes of LANE_W bits)
//   WORD_W  - width of one word on the narrow downstream port
//   WORDS   - words per frame
//   LANE_W  - width of a single result lane
//   IDX_W   - width of the word index within a frame
//   STAT_W  - width of the dropped-frame counter
//   drain_state_t - control state of the result drain
package systolic_pkg;

    localparam int DATA_W = 128;
    localparam int WORD_W = 32;
    localparam int WORDS  = DATA_W / WORD_W;
    localparam int LANE_W = 8;
    localparam int IDX_W  = 2;
    localparam int STAT_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } drain_state_t;

endpackage

// File: rtl/systolic_result_drain_frame_fifo.sv
// frame_fifo
// DEPTH-entry buffer of whole result frames with pop-before-push semantics:
// a push while full is legal when a pop happens in the same cycle.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   push_i, wdata_i  - write strobe and frame to store
//   pop_i            - discard the head frame
//   rdata_o          - head frame (registered storage, no path from wdata_i)
//   full_o, empty_o  - occupancy flags
//   count_o          - occupancy, 0..DEPTH
module frame_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    // A pop frees the head slot first, so a full buffer can still accept
    // a frame on the cycle it pops. Pointers wrap naturally at DEPTH.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the consumer masks the head while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/systolic_result_drain.sv
// systolic_result_drain
// Captures 128-bit result frames from the systolic array, buffers up to
// DEPTH of them and streams each out as WORD_W-bit words, lowest word first,
// on a valid/ready handshake. Frames arriving into a full buffer (with no
// same-cycle pop) are dropped and counted.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   res_valid_in, res_in    - frame strobe and frame data from the array
//   word_out, word_valid    - current output word and its valid
//   word_ready              - downstream accepts the word
//   word_last, word_idx     - final-word marker and position within frame
//   overflow, drop_cnt      - sticky drop flag and saturating drop count
//   clr_stat                - synchronous clear of overflow/drop_cnt
//   busy                    - buffer holds at least one frame
module systolic_result_drain #(
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int WORD_W = systolic_pkg::WORD_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid_in,
    input  logic [DATA_W-1:0] res_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last,
    output logic [1:0]        word_idx,
    output logic              overflow,
    output logic [7:0]        drop_cnt,
    input  logic              clr_stat,
    output logic              busy
);

    import systolic_pkg::*;

    localparam int WORDS_N = DATA_W / WORD_W;
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_N - 1);

    drain_state_t      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              overflow_q, overflow_d;
    logic [STAT_W-1:0] drop_q, drop_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [AW:0]       fifo_count;
    logic [DATA_W-1:0] head_frame;
    logic              xfer, drop;

    frame_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_frame_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (res_in),
        .pop_i   (fifo_pop),
        .rdata_o (head_frame),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Handshake decode. The head frame pops on the transfer of its last
    // word; that pop makes room, so a strobe on the same cycle is not a drop.
    always_comb begin
        xfer      = (state_q == SEND) && word_ready;
        fifo_pop  = xfer && (idx_q == LAST_IDX);
        drop      = res_valid_in && fifo_full && !fifo_pop;
        fifo_push = res_valid_in && !drop;

        idx_d = idx_q;
        if (xfer) begin
            idx_d = fifo_pop ? '0 : idx_q + 1'b1;
        end

        // SEND tracks non-zero occupancy, so it doubles as word_valid.
        state_d = state_q;
        case (state_q)
            EMPTY: if (fifo_push) state_d = SEND;
            SEND:  if (fifo_pop && !fifo_push && (fifo_count == (AW+1)'(1)))
                       state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        // A clear wins over a coincident drop.
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clr_stat) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Output is masked to zero while empty so stale storage never shows.
    assign word_valid = (state_q == SEND);
    assign busy       = !fifo_empty;
    assign word_out   = word_valid ? head_frame[32'(idx_q) * WORD_W +: WORD_W] : '0;
    assign word_last  = word_valid && (idx_q == LAST_IDX);
    assign word_idx   = idx_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain
// Directed bench for systolic_result_drain: single frame, overflow,
// simultaneous pop/push, backpressure, drop saturation with clear, and
// reset in the middle of a frame.
module tb_systolic_result_drain;

    logic         clk;
    logic         reset;
    logic         res_valid_in;
    logic [127:0] res_in;
    logic [31:0]  word_out;
    logic         word_valid;
    logic         word_ready;
    logic         word_last;
    logic [1:0]   word_idx;
    logic         overflow;
    logic [7:0]   drop_cnt;
    logic         clr_stat;
    logic         busy;

    int checkCount = 0;
    int errorCount = 0;

    systolic_result_drain #(
        .DATA_W (128),
        .WORD_W (32),
        .DEPTH  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .res_valid_in (res_valid_in),
        .res_in       (res_in),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_last    (word_last),
        .word_idx     (word_idx),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .clr_stat     (clr_stat),
        .busy         (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame whose four words are base, base+1, base+2, base+3 (word 0 lowest).
    function automatic logic [127:0] makeFrame(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, step past the rising edge, drop the strobes.
    task automatic applyStimulus(input logic valid, input logic [127:0] data,
                                 input logic ready, input logic clr);
        res_valid_in = valid;
        res_in       = data;
        word_ready   = ready;
        clr_stat     = clr;
        @(posedge clk);
        #1;
        res_valid_in = 1'b0;
        clr_stat     = 1'b0;
    endtask

    task automatic tick(input logic ready);
        applyStimulus(1'b0, 128'd0, ready, 1'b0);
    endtask

    // Check that word k of the frame is currently presented.
    task automatic checkWord(input string tag, input logic [127:0] frame, input int k);
        logic [31:0] expWord;
        expWord = frame[k*32 +: 32];
        checkOutput({tag, "_valid"}, 32'(word_valid), 32'd1);
        checkOutput({tag, "_data"},  word_out, expWord);
        checkOutput({tag, "_idx"},   32'(word_idx), 32'(k));
        checkOutput({tag, "_last"},  32'(word_last), (k == 3) ? 32'd1 : 32'd0);
    endtask

    // Drain one frame with ready held high, one word per cycle.
    task automatic drainFrame(input string tag, input logic [127:0] frame);
        for (int k = 0; k < 4; k++) begin
            checkWord($sformatf("%s_w%0d", tag, k), frame, k);
            tick(1'b1);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"},  32'(busy), 32'd0);
        checkOutput({tag, "_valid"}, 32'(word_valid), 32'd0);
        checkOutput({tag, "_last"},  32'(word_last), 32'd0);
        checkOutput({tag, "_idx"},   32'(word_idx), 32'd0);
        checkOutput({tag, "_data"},  word_out, 32'd0);
    endtask

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] frameA, frameB, frameC, frameD, frameE, frameG, frameH;
        logic         readySeq [7];
        int           expIdx;

        frameA = makeFrame(32'hA000_0000);
        frameB = makeFrame(32'hB000_0000);
        frameC = makeFrame(32'hC000_0000);
        frameD = makeFrame(32'hD000_0000);
        frameE = makeFrame(32'hE000_0010);
        frameG = makeFrame(32'h6000_0000);
        frameH = makeFrame(32'h7000_0000);
        readySeq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        reset        = 1'b0;
        res_valid_in = 1'b0;
        res_in       = '0;
        word_ready   = 1'b0;
        clr_stat     = 1'b0;

        // Reset values
        #1 reset = 1'b1;
        #1;
        checkIdle("rst");
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_dropcnt",  32'(drop_cnt), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        checkIdle("post_rst");

        // Single frame: words 1,2,3,4 back-to-back, then idle
        applyStimulus(1'b1, makeFrame(32'd1), 1'b1, 1'b0);
        drainFrame("single", makeFrame(32'd1));
        checkIdle("single_end");

        // Overflow: A and B buffered, C dropped
        applyStimulus(1'b1, frameA, 1'b0, 1'b0);
        applyStimulus(1'b1, frameB, 1'b0, 1'b0);
        applyStimulus(1'b1, frameC, 1'b0, 1'b0);
        checkOutput("ovf_flag",    32'(overflow), 32'd1);
        checkOutput("ovf_dropcnt", 32'(drop_cnt), 32'd1);
        checkOutput("ovf_busy",    32'(busy), 32'd1);
        checkWord("ovf_hold", frameA, 0);
        drainFrame("ovf_A", frameA);
        drainFrame("ovf_B", frameB);
        checkIdle("ovf_end");

        // Simultaneous pop and push on a full buffer
        applyStimulus(1'b1, frameA, 1'b0, 1'b0);
        applyStimulus(1'b1, frameB, 1'b0, 1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        checkWord("pp_A3", frameA, 3);
        applyStimulus(1'b1, frameD, 1'b1, 1'b0);
        checkOutput("pp_dropcnt", 32'(drop_cnt), 32'd1);
        drainFrame("pp_B", frameB);
        drainFrame("pp_D", frameD);
        checkIdle("pp_end");

        // Backpressure: ready pattern 1,0,0,1,0,1,1 across one frame
        applyStimulus(1'b1, frameE, 1'b0, 1'b0);
        expIdx = 0;
        for (int i = 0; i < 7; i++) begin
            checkWord($sformatf("bp_c%0d", i), frameE, expIdx);
            applyStimulus(1'b0, 128'd0, readySeq[i], 1'b0);
            if (readySeq[i]) expIdx++;
        end
        checkOutput("bp_words", 32'(expIdx), 32'd4);
        checkIdle("bp_end");

        // Saturation: 300 more drops on top of the earlier one
        applyStimulus(1'b1, frameA, 1'b0, 1'b0);
        applyStimulus(1'b1, frameB, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, frameC, 1'b0, 1'b0);
        end
        checkOutput("sat_dropcnt", 32'(drop_cnt), 32'd255);
        checkOutput("sat_flag",    32'(overflow), 32'd1);
        // Clear coinciding with a drop: clear wins, data kept
        applyStimulus(1'b1, frameC, 1'b0, 1'b1);
        checkOutput("clr_dropcnt", 32'(drop_cnt), 32'd0);
        checkOutput("clr_flag",    32'(overflow), 32'd0);
        checkOutput("clr_busy",    32'(busy), 32'd1);
        drainFrame("clr_A", frameA);
        drainFrame("clr_B", frameB);
        checkIdle("clr_end");

        // Reset after words 0 and 1 of a frame have transferred
        applyStimulus(1'b1, frameG, 1'b1, 1'b0);
        tick(1'b1);
        tick(1'b1);
        checkWord("mid_G2", frameG, 2);
        #1 reset = 1'b1;
        #1;
        checkIdle("mid_rst");
        @(negedge clk) reset = 1'b0;
        repeat (2) tick(1'b1);
        checkIdle("mid_wait");
        applyStimulus(1'b1, frameH, 1'b1, 1'b0);
        drainFrame("mid_H", frameH);
        checkIdle("mid_end");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
